// File: rtl/arm_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : arm_mem_pkg
// Brief  : Shared types and lane-enable constants for the MEM pipeline stage.
// Rev    : 1.0
// ============================================================================
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } mem_state_t;

  localparam logic [3:0] LANE_B0  = 4'b0001;
  localparam logic [3:0] LANE_B1  = 4'b0010;
  localparam logic [3:0] LANE_B2  = 4'b0100;
  localparam logic [3:0] LANE_B3  = 4'b1000;
  localparam logic [3:0] LANE_ALL = 4'b1111;

  function automatic logic [3:0] lane_mask(input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (addr_lo)
      2'd0:    mask = LANE_B0;
      2'd1:    mask = LANE_B1;
      2'd2:    mask = LANE_B2;
      default: mask = LANE_B3;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arm_mem_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module : arm_mem_lane_fmt
// Brief  : Little-endian store lane replication and load byte extraction.
// Rev    : 1.0
// ============================================================================
module arm_mem_lane_fmt
  import arm_mem_pkg::*;
(
  input  logic        byte_access,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [3:0]  word_we,
  input  logic [31:0] load_raw,
  output logic [31:0] store_wdata,
  output logic [3:0]  store_we,
  output logic [31:0] load_data
);

  always_comb begin
    store_wdata = store_data;
    store_we    = word_we & LANE_ALL;
    load_data   = load_raw;
    if (byte_access) begin
      // Replicate the byte on every lane so the memory only needs the enables.
      store_wdata = {4{store_data[7:0]}};
      store_we    = lane_mask(addr_lo);
      case (addr_lo)
        2'd0:    load_data = {24'h0, load_raw[7:0]};
        2'd1:    load_data = {24'h0, load_raw[15:8]};
        2'd2:    load_data = {24'h0, load_raw[23:16]};
        default: load_data = {24'h0, load_raw[31:24]};
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/arm_mem_stage.sv
`default_nettype none
// ============================================================================
// Module : arm_mem_stage
// Brief  : MEM pipeline stage: data-memory handshake, stall, forward, MEMWB regs.
// Rev    : 1.0
// ============================================================================
module arm_mem_stage
  import arm_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXMEM_data_result,
  input  logic [31:0] EXMEM_rd_data,
  input  logic        EXMEM_rd_we,
  input  logic        EXMEM_rd_data_sel,
  input  logic [3:0]  EXMEM_des_reg_num,
  input  logic [3:0]  EXMEM_mem_write_en,
  input  logic        EXMEM_internal_halted,
  input  logic        EXMEM_is_alu_for_mem_addr,
  input  logic        EXMEM_ld_byte_or_word,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_we,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic        MEMID_rd_we,
  output logic [3:0]  MEMID_rd_num,
  output logic [31:0] MEMID_forward_data,
  output logic        MEMWB_rd_we,
  output logic [3:0]  MEMWB_rd_num,
  output logic [31:0] MEMWB_rd_data,
  output logic        MEMWB_internal_halted
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wb_rd_we_q, wb_rd_we_d;
  logic [3:0]       wb_rd_num_q, wb_rd_num_d;
  logic [31:0]      wb_rd_data_q, wb_rd_data_d;
  logic             wb_halted_q, wb_halted_d;

  logic        mem_op, store_op;
  logic        req_raw, stall;
  logic [31:0] fmt_wdata, fmt_load, result;
  logic [3:0]  fmt_we;

  assign mem_op   = EXMEM_is_alu_for_mem_addr & ~EXMEM_internal_halted;
  assign store_op = mem_op & (|EXMEM_mem_write_en);

  arm_mem_lane_fmt u_lane_fmt (
    .byte_access (EXMEM_ld_byte_or_word),
    .addr_lo     (EXMEM_data_result[1:0]),
    .store_data  (EXMEM_rd_data),
    .word_we     (EXMEM_mem_write_en),
    .load_raw    (dmem_rdata),
    .store_wdata (fmt_wdata),
    .store_we    (fmt_we),
    .load_data   (fmt_load)
  );

  // EXMEM is frozen by mem_stall, so address/data stay stable while waiting.
  assign dmem_addr  = {EXMEM_data_result[31:2], 2'b00};
  assign dmem_wdata = fmt_wdata;
  assign dmem_we    = store_op ? fmt_we : 4'b0000;
  assign dmem_req   = req_raw & ~rst;
  assign mem_stall  = stall;
  assign mem_fault  = (state_q == ST_FAULT);

  assign result = EXMEM_rd_data_sel ? fmt_load : EXMEM_data_result;

  assign MEMID_rd_we        = EXMEM_rd_we & ~stall;
  assign MEMID_rd_num       = EXMEM_des_reg_num;
  assign MEMID_forward_data = result;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_raw = 1'b0;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_raw = mem_op;
        if (mem_op && !dmem_ack) begin
          stall   = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        req_raw = 1'b1;
        stall   = ~dmem_ack;
        if (dmem_ack) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == C_TIMEOUT) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        stall = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wb_rd_num_d  = EXMEM_des_reg_num;
    wb_rd_data_d = result;
    if (state_d == ST_FAULT) begin
      wb_rd_we_d  = 1'b0;
      wb_halted_d = 1'b1;
    end else if (stall) begin
      wb_rd_we_d  = 1'b0;
      wb_halted_d = 1'b0;
    end else begin
      wb_rd_we_d  = EXMEM_rd_we;
      wb_halted_d = EXMEM_internal_halted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wb_rd_we_q   <= 1'b0;
      wb_rd_num_q  <= 4'h0;
      wb_rd_data_q <= 32'h0;
      wb_halted_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_rd_we_q   <= wb_rd_we_d;
      wb_rd_num_q  <= wb_rd_num_d;
      wb_rd_data_q <= wb_rd_data_d;
      wb_halted_q  <= wb_halted_d;
    end
  end

  assign MEMWB_rd_we           = wb_rd_we_q;
  assign MEMWB_rd_num          = wb_rd_num_q;
  assign MEMWB_rd_data         = wb_rd_data_q;
  assign MEMWB_internal_halted = wb_halted_q;

endmodule
`default_nettype wire

// File: tb/tb_arm_mem_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_arm_mem_stage
// Brief  : Randomized + directed self-checking bench for arm_mem_stage.
// Rev    : 1.0
// ============================================================================
module tb_arm_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EXMEM_data_result, EXMEM_rd_data;
  logic        EXMEM_rd_we, EXMEM_rd_data_sel;
  logic [3:0]  EXMEM_des_reg_num, EXMEM_mem_write_en;
  logic        EXMEM_internal_halted, EXMEM_is_alu_for_mem_addr, EXMEM_ld_byte_or_word;
  logic        dmem_req, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_we;
  logic        mem_stall, mem_fault;
  logic        MEMID_rd_we;
  logic [3:0]  MEMID_rd_num;
  logic [31:0] MEMID_forward_data;
  logic        MEMWB_rd_we;
  logic [3:0]  MEMWB_rd_num;
  logic [31:0] MEMWB_rd_data;
  logic        MEMWB_internal_halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arm_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .EXMEM_data_result(EXMEM_data_result), .EXMEM_rd_data(EXMEM_rd_data),
    .EXMEM_rd_we(EXMEM_rd_we), .EXMEM_rd_data_sel(EXMEM_rd_data_sel),
    .EXMEM_des_reg_num(EXMEM_des_reg_num), .EXMEM_mem_write_en(EXMEM_mem_write_en),
    .EXMEM_internal_halted(EXMEM_internal_halted),
    .EXMEM_is_alu_for_mem_addr(EXMEM_is_alu_for_mem_addr),
    .EXMEM_ld_byte_or_word(EXMEM_ld_byte_or_word),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_fault(mem_fault),
    .MEMID_rd_we(MEMID_rd_we), .MEMID_rd_num(MEMID_rd_num),
    .MEMID_forward_data(MEMID_forward_data),
    .MEMWB_rd_we(MEMWB_rd_we), .MEMWB_rd_num(MEMWB_rd_num), .MEMWB_rd_data(MEMWB_rd_data),
    .MEMWB_internal_halted(MEMWB_internal_halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_nop();
    EXMEM_data_result         = 32'h0;
    EXMEM_rd_data             = 32'h0;
    EXMEM_rd_we               = 1'b0;
    EXMEM_rd_data_sel         = 1'b0;
    EXMEM_des_reg_num         = 4'h0;
    EXMEM_mem_write_en        = 4'h0;
    EXMEM_internal_halted     = 1'b0;
    EXMEM_is_alu_for_mem_addr = 1'b0;
    EXMEM_ld_byte_or_word     = 1'b0;
    dmem_ack                  = 1'b0;
    dmem_rdata                = 32'h0;
  endtask

  // Transaction-level model: one instruction, ack arriving d cycles after issue.
  task automatic run_instr(input logic [31:0] dr, input logic [31:0] rdd, input logic rwe,
                           input logic sel, input logic [3:0] rn, input logic [3:0] mwe,
                           input logic halted, input logic memacc, input logic isbyte,
                           input int d, input logic [31:0] rdata);
    logic        mem_op, store, exp_stall;
    logic [1:0]  lo;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata, ld, exp_res, byte_val;
    mem_op    = memacc && !halted;
    store     = mem_op && (mwe != 4'h0);
    lo        = dr[1:0];
    byte_val  = {24'h0, rdd[7:0]};
    exp_wdata = isbyte ? byte_val * 32'h01010101 : rdd;
    exp_we    = !store ? 4'h0 : (isbyte ? 4'(1 << lo) : mwe);
    ld        = isbyte ? ((rdata >> (8 * lo)) & 32'hFF) : rdata;
    exp_res   = sel ? ld : dr;

    EXMEM_data_result         = dr;
    EXMEM_rd_data             = rdd;
    EXMEM_rd_we               = rwe;
    EXMEM_rd_data_sel         = sel;
    EXMEM_des_reg_num         = rn;
    EXMEM_mem_write_en        = mwe;
    EXMEM_internal_halted     = halted;
    EXMEM_is_alu_for_mem_addr = memacc;
    EXMEM_ld_byte_or_word     = isbyte;

    for (int c = 0; c <= TO; c++) begin
      exp_stall  = mem_op && (c < d);
      dmem_ack   = mem_op ? (c == d) : 1'($urandom_range(0, 1));
      dmem_rdata = (c == d) ? rdata : $urandom;
      @(negedge clk);
      chk("req", {31'h0, dmem_req}, {31'h0, mem_op});
      chk("we", {28'h0, dmem_we}, {28'h0, exp_we});
      if (mem_op) chk("addr", dmem_addr, {dr[31:2], 2'b00});
      if (store) chk("wdata", dmem_wdata, exp_wdata);
      chk("stall", {31'h0, mem_stall}, {31'h0, exp_stall});
      chk("fwd_we", {31'h0, MEMID_rd_we}, {31'h0, rwe & ~exp_stall});
      if (!exp_stall) begin
        chk("fwd_num", {28'h0, MEMID_rd_num}, {28'h0, rn});
        chk("fwd_data", MEMID_forward_data, exp_res);
      end
      @(posedge clk);
      #1;
      if (exp_stall) begin
        chk("bubble_we", {31'h0, MEMWB_rd_we}, 32'h0);
        chk("bubble_halt", {31'h0, MEMWB_internal_halted}, 32'h0);
      end else begin
        chk("wb_we", {31'h0, MEMWB_rd_we}, {31'h0, rwe});
        chk("wb_num", {28'h0, MEMWB_rd_num}, {28'h0, rn});
        chk("wb_data", MEMWB_rd_data, exp_res);
        chk("wb_halt", {31'h0, MEMWB_internal_halted}, {31'h0, halted});
        break;
      end
    end
    dmem_ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'h0, dmem_req}, 32'h0);
    chk({tag, "_fault"}, {31'h0, mem_fault}, 32'h0);
    chk({tag, "_stall"}, {31'h0, mem_stall}, 32'h0);
    chk({tag, "_wb_we"}, {31'h0, MEMWB_rd_we}, 32'h0);
    chk({tag, "_wb_num"}, {28'h0, MEMWB_rd_num}, 32'h0);
    chk({tag, "_wb_data"}, MEMWB_rd_data, 32'h0);
    chk({tag, "_wb_halt"}, {31'h0, MEMWB_internal_halted}, 32'h0);
  endtask

  initial begin
    logic        memacc, halted, isbyte, store_sel;
    logic [3:0]  mwe;
    rst = 1'b1;
    set_nop();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // Directed scenarios
    run_instr(32'h1234, 32'h0, 1'b1, 1'b0, 4'd3, 4'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    run_instr(32'h100, 32'h0, 1'b1, 1'b1, 4'd5, 4'h0, 1'b0, 1'b1, 1'b0, 0, 32'hDEADBEEF);
    run_instr(32'h103, 32'h0, 1'b1, 1'b1, 4'd6, 4'h0, 1'b0, 1'b1, 1'b1, 3, 32'hAABBCCDD);
    run_instr(32'h102, 32'h5A, 1'b0, 1'b0, 4'd0, 4'h1, 1'b0, 1'b1, 1'b1, 1, 32'h0);
    run_instr(32'h200, 32'hCAFEF00D, 1'b0, 1'b0, 4'd0, 4'hF, 1'b0, 1'b1, 1'b0, TO, 32'h0);
    run_instr(32'h104, 32'h0, 1'b0, 1'b0, 4'd0, 4'h0, 1'b1, 1'b1, 1'b0, 2, 32'h0);

    for (int i = 0; i < 300; i++) begin
      memacc    = ($urandom_range(0, 9) < 7);
      halted    = ($urandom_range(0, 9) == 0);
      isbyte    = 1'($urandom_range(0, 1));
      store_sel = 1'($urandom_range(0, 1));
      mwe       = store_sel ? 4'($urandom_range(1, 15)) : 4'h0;
      run_instr($urandom, $urandom, 1'($urandom_range(0, 1)),
                memacc && !halted && !store_sel, 4'($urandom_range(0, 15)),
                mwe, halted, memacc, isbyte, $urandom_range(0, TO), $urandom);
    end

    // Reset while waiting, with an ack in the same cycle
    run_instr(32'h40, 32'h0, 1'b1, 1'b0, 4'd7, 4'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    EXMEM_data_result         = 32'h300;
    EXMEM_rd_we               = 1'b1;
    EXMEM_rd_data_sel         = 1'b1;
    EXMEM_des_reg_num         = 4'd9;
    EXMEM_is_alu_for_mem_addr = 1'b1;
    dmem_ack                  = 1'b0;
    @(negedge clk);
    chk("rw_stall", {31'h0, mem_stall}, 32'h1);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h11223344;
    @(negedge clk);
    chk("rw_req_in_rst", {31'h0, dmem_req}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_nop();
    @(negedge clk);
    check_reset_outputs("rw");

    // Timeout to FAULT after exactly TO wait cycles
    @(posedge clk);
    #1;
    EXMEM_data_result         = 32'h500;
    EXMEM_rd_we               = 1'b1;
    EXMEM_rd_data_sel         = 1'b1;
    EXMEM_des_reg_num         = 4'd2;
    EXMEM_is_alu_for_mem_addr = 1'b1;
    dmem_ack                  = 1'b0;
    for (int c = 0; c <= TO; c++) begin
      @(negedge clk);
      chk("to_stall", {31'h0, mem_stall}, 32'h1);
      chk("to_req", {31'h0, dmem_req}, 32'h1);
      chk("to_nofault", {31'h0, mem_fault}, 32'h0);
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 4; c++) begin
      chk("flt_wb_halt", {31'h0, MEMWB_internal_halted}, 32'h1);
      chk("flt_wb_we", {31'h0, MEMWB_rd_we}, 32'h0);
      dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("flt_fault", {31'h0, mem_fault}, 32'h1);
      chk("flt_req", {31'h0, dmem_req}, 32'h0);
      chk("flt_stall", {31'h0, mem_stall}, 32'h1);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    set_nop();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("flt_rst");

    // Stage is usable again after leaving FAULT
    @(posedge clk);
    #1;
    run_instr(32'h600, 32'h0, 1'b1, 1'b1, 4'd4, 4'h0, 1'b0, 1'b1, 1'b0, 1, 32'h87654321);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
